// File: rtl/axi_arbiter.sv
// Two-requester (fetch/LSU) round-robin arbiter that sequences one single-beat
// AXI4 read or write per grant and returns a one-cycle response pulse.
module axi_arbiter #(
  parameter int          ADDR_W  = 64,
  parameter int          DATA_W  = 64,
  parameter logic [3:0]  ID_INST = 4'd0,
  parameter logic [3:0]  ID_DATA = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction requester
  input  logic                  inst_req,
  input  logic                  inst_wr,
  input  logic [DATA_W/8-1:0]   inst_strb,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic [DATA_W-1:0]     inst_wdata,
  output logic                  inst_resp,
  output logic [DATA_W-1:0]     inst_rdata,
  output logic                  inst_err,
  // data requester
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [DATA_W/8-1:0]   data_strb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_resp,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  data_err,
  // AXI read address / data
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [3:0]            arid,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  // AXI write address / data / response
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [3:0]            awid,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;          // 1 = data requester owns the bus
  logic                last_q, last_d;        // 1 = data was granted last
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                wr_q, wr_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          id_q, id_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                take_data;

  logic arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic inst_resp_q, data_resp_q;

  // Single-beat bursts only, so the last flag carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_d      = wr_q;
    strb_d    = strb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    id_d      = id_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    take_data = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (inst_req || data_req) begin
          // On a tie the requester that did not win last time goes first.
          take_data = data_req && (!inst_req || !last_q);
          gnt_d     = take_data;
          wr_d      = take_data ? data_wr    : inst_wr;
          strb_d    = take_data ? data_strb  : inst_strb;
          addr_d    = take_data ? data_addr  : inst_addr;
          wdata_d   = take_data ? data_wdata : inst_wdata;
          id_d      = take_data ? ID_DATA    : ID_INST;
          rdata_d   = '0;
          err_d     = 1'b0;
          state_d   = wr_d ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        if (arvalid_q && arready) state_d = S_R;
      end
      S_R: begin
        if (rready_q && rvalid) begin
          rdata_d = rdata;
          err_d   = (rresp != 2'b00);
          state_d = S_RESP;
        end
      end
      S_AW_W: begin
        aw_done_d = aw_done_q || (awvalid_q && awready);
        w_done_d  = w_done_q  || (wvalid_q  && wready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end
      end
      S_B: begin
        if (bready_q && bvalid) begin
          rdata_d = '0;
          err_d   = (bresp != 2'b00);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      wr_q        <= 1'b0;
      strb_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      id_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      inst_resp_q <= 1'b0;
      data_resp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      wr_q        <= wr_d;
      strb_q      <= strb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      // Handshake outputs are decoded from the next state so they are registered.
      arvalid_q   <= (state_d == S_AR);
      rready_q    <= (state_d == S_R);
      awvalid_q   <= (state_d == S_AW_W) && !aw_done_d;
      wvalid_q    <= (state_d == S_AW_W) && !w_done_d;
      bready_q    <= (state_d == S_B);
      inst_resp_q <= (state_d == S_RESP) && !gnt_d;
      data_resp_q <= (state_d == S_RESP) &&  gnt_d;
    end
  end

  assign arvalid    = arvalid_q;
  assign araddr     = addr_q;
  assign arid       = id_q;
  assign rready     = rready_q;
  assign awvalid    = awvalid_q;
  assign awaddr     = addr_q;
  assign awid       = id_q;
  assign wvalid     = wvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = strb_q;
  assign wlast      = 1'b1;
  assign bready     = bready_q;

  assign inst_resp  = inst_resp_q;
  assign inst_rdata = rdata_q;
  assign inst_err   = err_q;
  assign data_resp  = data_resp_q;
  assign data_rdata = rdata_q;
  assign data_err   = err_q;

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed-vector bench for axi_arbiter: reads, writes, arbitration order,
// error responses, AR backpressure and asynchronous reset mid-transaction.
module tb_axi_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic              clk, rst;
  logic              inst_req, inst_wr, inst_resp, inst_err;
  logic [STRB_W-1:0] inst_strb;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata, inst_rdata;
  logic              data_req, data_wr, data_resp, data_err;
  logic [STRB_W-1:0] data_strb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata, data_rdata;
  logic              arvalid, arready, rvalid, rready, rlast;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [3:0]        arid, awid;
  logic [DATA_W-1:0] rdata, wdata;
  logic [1:0]        rresp, bresp;
  logic              awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [STRB_W-1:0] wstrb;

  int n_cmp = 0;
  int n_mis = 0;

  axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_INST(4'd0), .ID_DATA(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_strb(inst_strb), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_resp(inst_resp), .inst_rdata(inst_rdata), .inst_err(inst_err),
    .data_req(data_req), .data_wr(data_wr), .data_strb(data_strb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_resp(data_resp), .data_rdata(data_rdata), .data_err(data_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Starts in IDLE, completes one minimum-latency read for one requester.
  task automatic run_read(input bit is_d, input logic [63:0] a, input logic [63:0] rd,
                          input logic [1:0] rr);
    logic [63:0] exp_id;
    logic [63:0] exp_err;
    exp_id  = is_d ? 64'd1 : 64'd0;
    exp_err = (rr != 2'b00) ? 64'd1 : 64'd0;
    if (is_d) begin data_req = 1'b1; data_wr = 1'b0; data_addr = a; end
    else      begin inst_req = 1'b1; inst_wr = 1'b0; inst_addr = a; end
    arready = 1'b1;
    tick();
    chk("rd.arvalid", arvalid, 1);
    chk("rd.araddr", araddr, a);
    chk("rd.arid", arid, exp_id);
    tick();
    chk("rd.arvalid_drop", arvalid, 0);
    chk("rd.rready", rready, 1);
    rvalid = 1'b1; rdata = rd; rresp = rr;
    tick();
    chk("rd.resp_own", is_d ? data_resp : inst_resp, 1);
    chk("rd.resp_other", is_d ? inst_resp : data_resp, 0);
    chk("rd.rdata", is_d ? data_rdata : inst_rdata, rd);
    chk("rd.err", is_d ? data_err : inst_err, exp_err);
    chk("rd.rready_drop", rready, 0);
    rvalid = 1'b0; rresp = 2'b00;
    if (is_d) data_req = 1'b0; else inst_req = 1'b0;
    tick();
    chk("rd.resp_clear", is_d ? data_resp : inst_resp, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_d;
    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_strb = '0; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_strb = '0; data_addr = '0; data_wdata = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 1'b1;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    tick();
    tick();
    chk("rst.arvalid", arvalid, 0);
    chk("rst.awvalid", awvalid, 0);
    chk("rst.wvalid", wvalid, 0);
    chk("rst.rready", rready, 0);
    chk("rst.bready", bready, 0);
    chk("rst.inst_resp", inst_resp, 0);
    chk("rst.data_resp", data_resp, 0);
    chk("rst.araddr", araddr, 0);
    chk("rst.wlast", wlast, 1);
    rst = 1'b0;

    // single read from the instruction port
    run_read(1'b0, 64'h0000_0000_8000_0000, 64'h1122_3344_5566_7788, 2'b00);

    // write with W accepted before AW
    arready = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 64'h100; data_strb = 8'h0F;
    data_wdata = 64'hDEAD_BEEF;
    tick();
    chk("wr.awvalid", awvalid, 1);
    chk("wr.wvalid", wvalid, 1);
    chk("wr.awaddr", awaddr, 64'h100);
    chk("wr.awid", awid, 1);
    chk("wr.wdata", wdata, 64'hDEAD_BEEF);
    chk("wr.wstrb", wstrb, 8'h0F);
    chk("wr.arvalid", arvalid, 0);
    wready = 1'b1;
    tick();
    chk("wr.wvalid_drop", wvalid, 0);
    chk("wr.awvalid_hold2", awvalid, 1);
    wready = 1'b0;
    data_addr = 64'h999;
    tick();
    chk("wr.awvalid_hold3", awvalid, 1);
    chk("wr.awaddr_frozen", awaddr, 64'h100);
    awready = 1'b1;
    tick();
    chk("wr.awvalid_drop", awvalid, 0);
    chk("wr.bready", bready, 1);
    awready = 1'b0;
    tick();
    chk("wr.no_early_resp", data_resp, 0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    chk("wr.data_resp", data_resp, 1);
    chk("wr.inst_resp", inst_resp, 0);
    chk("wr.rdata_zero", data_rdata, 0);
    chk("wr.err", data_err, 0);
    chk("wr.bready_drop", bready, 0);
    bvalid = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    tick();
    chk("wr.resp_clear", data_resp, 0);

    // simultaneous requests after reset: I, D, I, D
    do_reset();
    arready = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 64'h1000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 64'h2000;
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2 == 1) ? 64'd1 : 64'd0;
      tick();
      chk("rr.arid", arid, exp_d);
      chk("rr.araddr", araddr, exp_d[0] ? 64'h2000 : 64'h1000);
      tick();
      rvalid = 1'b1; rdata = 64'hA0 + 64'(i);
      tick();
      chk("rr.inst_resp", inst_resp, exp_d[0] ? 64'd0 : 64'd1);
      chk("rr.data_resp", data_resp, exp_d);
      chk("rr.rdata", exp_d[0] ? data_rdata : inst_rdata, 64'hA0 + 64'(i));
      rvalid = 1'b0;
      if (i == 3) begin inst_req = 1'b0; data_req = 1'b0; end
      tick();
    end

    // error response then an OKAY read
    run_read(1'b1, 64'h200, 64'hAAAA, 2'b10);
    run_read(1'b1, 64'h208, 64'h5555, 2'b00);

    // AR backpressure with a changing request address
    arready = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 64'h3000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.arvalid", arvalid, 1);
      chk("bp.araddr", araddr, 64'h3000);
      chk("bp.resp", inst_resp, 0);
      inst_addr = 64'h3000 + 64'(8 * (i + 1));
    end
    arready = 1'b1;
    tick();
    chk("bp.rready", rready, 1);
    chk("bp.arvalid_drop", arvalid, 0);
    rvalid = 1'b1; rdata = 64'h77;
    tick();
    chk("bp.resp", inst_resp, 1);
    chk("bp.rdata", inst_rdata, 64'h77);
    rvalid = 1'b0; inst_req = 1'b0;
    tick();

    // asynchronous reset while in R
    inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 64'h40;
    tick();
    tick();
    chk("mr.rready_before", rready, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr.rready", rready, 0);
    chk("mr.arvalid", arvalid, 0);
    chk("mr.inst_resp", inst_resp, 0);
    chk("mr.araddr", araddr, 0);
    inst_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mr.idle_arvalid", arvalid, 0);
    run_read(1'b0, 64'h48, 64'hCAFE_F00D, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
